// File: rtl/filters_pkg.sv
// Shared types and helpers for the filter rounding/saturation datapath.
package filters_pkg;

   typedef enum logic [1:0] {
      RND_TRUNC   = 2'b00,
      RND_HALF_UP = 2'b01,
      RND_CONV    = 2'b10
   } rnd_mode_t;

   // Rounded width keeps one extra MSB so the round-up carry cannot overflow.
   function automatic int unsigned rnd_width(input int unsigned iw, input int unsigned shift);
      return iw - shift + 1;
   endfunction

endpackage

// File: rtl/filters_round_sat_lane.sv
// One channel of round + overflow detect + clamp/wrap, split at the S1 register:
// the rounding half feeds S1, the saturation half works on the registered value.
module filters_round_sat_lane
   import filters_pkg::*;
#(
   parameter int unsigned IW    = 16,
   parameter int unsigned SHIFT = 4,
   parameter int unsigned OW    = 12,
   parameter int unsigned RW    = rnd_width(IW, SHIFT)
) (
   input  logic [IW-1:0] i_x,
   input  rnd_mode_t     i_mode,
   output logic [RW-1:0] o_rnd,
   input  logic [RW-1:0] i_rnd,
   input  logic          i_sat_en,
   output logic [OW-1:0] o_y,
   output logic          o_ovf
);

   logic [IW:0]    w_v;
   logic [RW-OW:0] w_top;

   assign w_v = {i_x[IW-1], i_x};

   if (SHIFT == 0) begin : g_pass
      assign o_rnd = w_v;
   end else begin : g_rnd
      localparam logic [SHIFT-1:0] H = SHIFT'(1) << (SHIFT - 1);

      logic [RW-1:0] w_trunc;
      logic [RW-1:0] w_half;
      logic          w_tie;

      // Adding h before the shift only carries in when the top dropped bit is set.
      assign w_trunc = w_v[IW:SHIFT];
      assign w_half  = w_trunc + RW'(i_x[SHIFT-1]);
      assign w_tie   = (i_x[SHIFT-1:0] == H);

      always_comb begin
         o_rnd = w_trunc;
         case (i_mode)
            RND_HALF_UP: o_rnd = w_half;
            RND_CONV:    o_rnd = w_tie ? {w_half[RW-1:1], 1'b0} : w_half;
            default:     o_rnd = w_trunc;
         endcase
      end
   end

   // In range only when all bits from the output sign bit upward agree.
   assign w_top = i_rnd[RW-1:OW-1];
   assign o_ovf = !((&w_top) | ~(|w_top));

   always_comb begin
      o_y = i_rnd[OW-1:0];
      if (o_ovf && i_sat_en) begin
         o_y = i_rnd[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/filters_round_sat_pipe.sv
// Multi-channel two-stage round/saturate pipeline with valid/ready flow control,
// per-channel sticky overflow flags and a saturating overflow event counter.
module filters_round_sat_pipe
   import filters_pkg::*;
#(
   parameter int unsigned IW    = 16,
   parameter int unsigned SHIFT = 4,
   parameter int unsigned OW    = 12,
   parameter int unsigned CH    = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [CH*IW-1:0]    x_i,
   input  logic [1:0]          rnd_mode_i,
   input  logic                sat_en_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [CH*OW-1:0]    y_o,
   output logic [CH-1:0]       ovf_o,
   output logic [CH-1:0]       sticky_ovf_o,
   output logic [CNT_W-1:0]    ovf_cnt_o,
   input  logic                clear_i
);

   localparam int unsigned RW = rnd_width(IW, SHIFT);

   if (OW > IW - SHIFT || OW < 2) begin : g_bad_cfg
      $error("filters_round_sat_pipe: OW must satisfy 2 <= OW <= IW-SHIFT");
   end

   logic [RW-1:0]    w_rnd    [CH];
   logic [RW-1:0]    r_s1_rnd [CH];
   logic             r_s1_vld;
   logic             r_s1_sat;
   logic [CH*OW-1:0] w_y;
   logic [CH-1:0]    w_ovf;
   logic             r_s2_vld;
   logic [CH*OW-1:0] r_y;
   logic [CH-1:0]    r_ovf;
   logic [CH-1:0]    r_sticky;
   logic [CNT_W-1:0] r_cnt;
   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_out_xfer;

   for (genvar c = 0; c < CH; c++) begin : g_lane
      filters_round_sat_lane #(
         .IW    (IW),
         .SHIFT (SHIFT),
         .OW    (OW)
      ) u_lane (
         .i_x      (x_i[c*IW +: IW]),
         .i_mode   (rnd_mode_t'(rnd_mode_i)),
         .o_rnd    (w_rnd[c]),
         .i_rnd    (r_s1_rnd[c]),
         .i_sat_en (r_s1_sat),
         .o_y      (w_y[c*OW +: OW]),
         .o_ovf    (w_ovf[c])
      );
   end

   assign w_s2_adv   = !r_s2_vld || ready_i;
   assign w_s1_adv   = !r_s1_vld || w_s2_adv;
   assign w_out_xfer = r_s2_vld && ready_i;
   assign ready_o    = w_s1_adv && !rst_i;

   // S1: rounded value plus the saturation mode that travels with it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1_vld <= 1'b0;
         r_s1_sat <= 1'b0;
         for (int c = 0; c < CH; c++) r_s1_rnd[c] <= '0;
      end else if (w_s1_adv) begin
         r_s1_vld <= valid_i;
         if (valid_i) begin
            r_s1_sat <= sat_en_i;
            for (int c = 0; c < CH; c++) r_s1_rnd[c] <= w_rnd[c];
         end
      end
   end

   // S2: final sample; ovf is forced low whenever the stage drains empty.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s2_vld <= 1'b0;
         r_y      <= '0;
         r_ovf    <= '0;
      end else if (w_s2_adv) begin
         r_s2_vld <= r_s1_vld;
         r_ovf    <= r_s1_vld ? w_ovf : '0;
         if (r_s1_vld) r_y <= w_y;
      end
   end

   // A coincident overflow event overrides clear so it is never lost.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sticky <= '0;
         r_cnt    <= '0;
      end else if (w_out_xfer && (|r_ovf)) begin
         r_sticky <= clear_i ? r_ovf : (r_sticky | r_ovf);
         if (clear_i)          r_cnt <= CNT_W'(1);
         else if (~&r_cnt)     r_cnt <= r_cnt + CNT_W'(1);
      end else if (clear_i) begin
         r_sticky <= '0;
         r_cnt    <= '0;
      end
   end

   assign valid_o      = r_s2_vld;
   assign y_o          = r_y;
   assign ovf_o        = r_ovf;
   assign sticky_ovf_o = r_sticky;
   assign ovf_cnt_o    = r_cnt;

endmodule

// File: tb/tb_filters_round_sat_pipe.sv
// Directed bench for filters_round_sat_pipe with an integer reference model.
module tb_filters_round_sat_pipe;

   localparam int unsigned IW    = 16;
   localparam int unsigned SHIFT = 4;
   localparam int unsigned OW    = 12;
   localparam int unsigned CH    = 2;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             valid_i;
   logic             ready_i;
   logic             sat_en_i;
   logic             clear_i;
   logic [1:0]       rnd_mode_i;
   logic [CH*IW-1:0] x_i;

   logic             ready_o, valid_o;
   logic [CH*OW-1:0] y_o;
   logic [CH-1:0]    ovf_o, sticky_o;
   logic [15:0]      cnt_o;

   logic             ready2, valid2;
   logic [CH*OW-1:0] y2;
   logic [CH-1:0]    ovf2, sticky2;
   logic [1:0]       cnt2;

   int vectors     = 0;
   int miscompares = 0;

   logic [25:0] q[$];
   logic [25:0] hold;
   logic        stalled;

   always #5 clk = ~clk;

   filters_round_sat_pipe #(.IW(IW), .SHIFT(SHIFT), .OW(OW), .CH(CH), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .x_i(x_i),
      .rnd_mode_i(rnd_mode_i), .sat_en_i(sat_en_i), .valid_o(valid_o), .ready_i(ready_i),
      .y_o(y_o), .ovf_o(ovf_o), .sticky_ovf_o(sticky_o), .ovf_cnt_o(cnt_o), .clear_i(clear_i)
   );

   filters_round_sat_pipe #(.IW(IW), .SHIFT(SHIFT), .OW(OW), .CH(CH), .CNT_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready2), .x_i(x_i),
      .rnd_mode_i(rnd_mode_i), .sat_en_i(sat_en_i), .valid_o(valid2), .ready_i(ready_i),
      .y_o(y2), .ovf_o(ovf2), .sticky_ovf_o(sticky2), .ovf_cnt_o(cnt2), .clear_i(clear_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: floor division by 16 on plain integers, then range check.
   function automatic logic [12:0] model1(input logic [15:0] x, input logic [1:0] m, input logic sat);
      int v, qq, rem, r;
      logic o;
      v   = int'($signed(x));
      qq  = v >>> 4;
      rem = v - qq * 16;
      case (m)
         2'b01:   r = (rem >= 8) ? qq + 1 : qq;
         2'b10: begin
            if (rem > 8)      r = qq + 1;
            else if (rem < 8) r = qq;
            else              r = (qq % 2 == 0) ? qq : qq + 1;
         end
         default: r = qq;
      endcase
      o = (r > 2047) || (r < -2048);
      if (o && sat) r = (r > 0) ? 2047 : -2048;
      return {o, 12'(r)};
   endfunction

   function automatic logic [25:0] model2(input logic [31:0] x, input logic [1:0] m, input logic sat);
      logic [12:0] a, b;
      a = model1(x[15:0], m, sat);
      b = model1(x[31:16], m, sat);
      return {b[12], a[12], b[11:0], a[11:0]};
   endfunction

   function automatic logic [15:0] rx();
      if ($urandom_range(0, 3) == 0) return 16'h7FF8 + 16'($urandom_range(0, 7));
      return 16'($urandom);
   endfunction

   // One isolated sample: accept, check 2-cycle emergence, then transfer it out.
   task automatic send1(input logic [15:0] x0, input logic [15:0] x1, input logic [1:0] m,
                        input logic sat, input logic [11:0] e0, input logic [11:0] e1,
                        input logic [1:0] eovf, input logic clr, input string tag);
      valid_i = 1'b1; ready_i = 1'b1; x_i = {x1, x0}; rnd_mode_i = m; sat_en_i = sat;
      #1;
      chk({tag, "_rdy"}, ready_o, 1'b1);
      step();
      valid_i = 1'b0; x_i = '0;
      chk({tag, "_lat1"}, valid_o, 1'b0);
      step();
      chk({tag, "_vld"}, valid_o, 1'b1);
      chk({tag, "_y"}, y_o, {e1, e0});
      chk({tag, "_ovf"}, ovf_o, eovf);
      clear_i = clr;
      step();
      clear_i = 1'b0;
      chk({tag, "_done"}, valid_o, 1'b0);
   endtask

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sat_en_i = 1'b1; clear_i = 1'b0;
      rnd_mode_i = 2'b00; x_i = '0;
      step(); step();
      rst_i = 1'b0;
      #1;
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_y", y_o, '0);
      chk("rst_ovf", ovf_o, '0);
      chk("rst_sticky", sticky_o, '0);
      chk("rst_cnt", cnt_o, '0);

      // Rounding modes on +1.5, -1.5, +2.5
      send1(16'd24, 16'hFFE8, 2'b00, 1'b1, 12'd1, 12'hFFE, 2'b00, 1'b0, "trunc_a");
      send1(16'd40, 16'd0,    2'b00, 1'b1, 12'd2, 12'd0,   2'b00, 1'b0, "trunc_b");
      send1(16'd24, 16'hFFE8, 2'b01, 1'b1, 12'd2, 12'hFFF, 2'b00, 1'b0, "half_a");
      send1(16'd40, 16'd0,    2'b01, 1'b1, 12'd3, 12'd0,   2'b00, 1'b0, "half_b");
      send1(16'd24, 16'hFFE8, 2'b10, 1'b1, 12'd2, 12'hFFE, 2'b00, 1'b0, "conv_a");
      send1(16'd40, 16'd0,    2'b10, 1'b1, 12'd2, 12'd0,   2'b00, 1'b0, "conv_b");
      send1(16'd40, 16'hFFE8, 2'b11, 1'b1, 12'd2, 12'hFFE, 2'b00, 1'b0, "resv");

      // Rounding carry beyond the output range
      send1(16'h7FF8, 16'd0,    2'b01, 1'b1, 12'h7FF, 12'd0,   2'b01, 1'b0, "carry_sat");
      send1(16'h7FF8, 16'd0,    2'b01, 1'b0, 12'h800, 12'd0,   2'b01, 1'b0, "carry_wrap");
      send1(16'd0,    16'h8000, 2'b00, 1'b1, 12'd0,   12'h800, 2'b00, 1'b0, "min_trunc");
      chk("cnt_after_carry", cnt_o, 16'd2);
      chk("sticky_after_carry", sticky_o, 2'b01);
      chk("cnt2_after_carry", cnt2, 2'd2);

      clear_i = 1'b1; step(); clear_i = 1'b0;
      chk("clr_cnt", cnt_o, 16'd0);
      chk("clr_sticky", sticky_o, 2'b00);
      chk("clr_cnt2", cnt2, 2'd0);

      for (int i = 0; i < 3; i++)
         send1(16'd0, 16'h7FFF, 2'b01, 1'b1, 12'd0, 12'h7FF, 2'b10, 1'b0, "ch1_ovf");
      chk("ch1_sticky", sticky_o, 2'b10);
      chk("ch1_cnt", cnt_o, 16'd3);
      chk("ch1_cnt2", cnt2, 2'd3);

      clear_i = 1'b1; step(); clear_i = 1'b0;
      chk("idle_clr_cnt", cnt_o, 16'd0);
      chk("idle_clr_sticky", sticky_o, 2'b00);

      send1(16'h7FF8, 16'h7FF8, 2'b01, 1'b1, 12'h7FF, 12'h7FF, 2'b11, 1'b1, "clr_coinc");
      chk("coinc_cnt", cnt_o, 16'd1);
      chk("coinc_sticky", sticky_o, 2'b11);

      clear_i = 1'b1; step(); clear_i = 1'b0;
      for (int i = 0; i < 5; i++)
         send1(16'h7FF8, 16'd0, 2'b01, 1'b0, 12'h800, 12'd0, 2'b01, 1'b0, "five");
      chk("five_cnt", cnt_o, 16'd5);
      chk("five_cnt2_sat", cnt2, 2'd3);
      chk("five_sticky", sticky_o, 2'b01);

      // Back-to-back stream, ready_i high throughout
      ready_i = 1'b1;
      for (int i = 0; i < 102; i++) begin
         if (i < 100) begin
            valid_i = 1'b1; x_i = {rx(), rx()};
            rnd_mode_i = 2'($urandom_range(0, 3)); sat_en_i = 1'($urandom_range(0, 1));
            q.push_back(model2(x_i, rnd_mode_i, sat_en_i));
         end else begin
            valid_i = 1'b0;
         end
         step();
         if (i == 0)        chk("stream_lat", valid_o, 1'b0);
         else if (i <= 100) chk("stream", {valid_o, ovf_o, y_o}, {1'b1, q.pop_front()});
         else               chk("stream_end", valid_o, 1'b0);
      end

      // Random input with a 5-cycle output stall
      for (int i = 0; i < 60; i++) begin
         ready_i = !(i >= 20 && i < 25);
         valid_i = (i >= 18 && i < 25) ? 1'b1 : 1'($urandom_range(0, 1));
         x_i = {rx(), rx()};
         rnd_mode_i = 2'($urandom_range(0, 3)); sat_en_i = 1'($urandom_range(0, 1));
         #1;
         chk("bp_ready", ready_o, (q.size() < 2) || ready_i);
         if (i == 20) chk("bp_full", ready_o, 1'b0);
         if (valid_o && ready_i) begin
            if (q.size() == 0) chk("bp_extra", valid_o, 1'b0);
            else               chk("bp_data", {ovf_o, y_o}, q.pop_front());
         end
         stalled = valid_o && !ready_i;
         hold    = {ovf_o, y_o};
         if (valid_i && ready_o) q.push_back(model2(x_i, rnd_mode_i, sat_en_i));
         step();
         if (stalled) chk("bp_hold", {valid_o, ovf_o, y_o}, {1'b1, hold});
      end
      valid_i = 1'b0; ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (valid_o) begin
            if (q.size() == 0) chk("drain_extra", valid_o, 1'b0);
            else               chk("drain_data", {ovf_o, y_o}, q.pop_front());
         end
         step();
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
      chk("drain_valid", valid_o, 1'b0);

      // Reset with two samples in flight
      ready_i = 1'b0; valid_i = 1'b1; x_i = {16'h7FF8, 16'h7FF8};
      rnd_mode_i = 2'b01; sat_en_i = 1'b1;
      step(); step();
      valid_i = 1'b0;
      #2 rst_i = 1'b1;
      #1 chk("rst_async_valid", valid_o, 1'b0);
      step();
      rst_i = 1'b0;
      #1;
      chk("midrst_valid", valid_o, 1'b0);
      chk("midrst_ready", ready_o, 1'b1);
      chk("midrst_cnt", cnt_o, 16'd0);
      chk("midrst_sticky", sticky_o, 2'b00);
      chk("midrst_ovf", ovf_o, 2'b00);
      send1(16'd40, 16'd24, 2'b00, 1'b1, 12'd2, 12'd1, 2'b00, 1'b0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
